ram_fetch_buffer: RTL and testbench



---
 rtl/ram_fetch_buffer_if.sv | 41 ++++
 rtl/ram_fetch_buffer.sv | 136 +++++++++++++
 tb/tb_ram_fetch_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fetch_buffer_if.sv
// Bundle of the command, RAM-read and MXU-stream signals around ram_fetch_buffer.
// The slave modport is the buffer's view; master is the environment driving it.
interface ram_fetch_buffer_if #(
  parameter int RAM_WIDTH = 128,
  parameter int RAM_AW    = 8,
  parameter int BYTE_AW   = $clog2(RAM_WIDTH/8)
);
  logic                   cmd_vld;
  logic                   cmd_rdy;
  logic [RAM_AW-1:0]      cmd_start_addr;
  logic [RAM_AW-1:0]      cmd_stride;
  logic [15:0]            cmd_len;
  logic [BYTE_AW-1:0]     cmd_start_byte;
  logic [BYTE_AW-1:0]     cmd_end_byte;
  logic                   ram_rd_vld;
  logic [RAM_AW-1:0]      ram_rd_addr;
  logic                   ram_rd_data_vld;
  logic [RAM_WIDTH-1:0]   ram_rd_data;
  logic                   mxu_vld;
  logic                   mxu_rdy;
  logic [RAM_WIDTH-1:0]   mxu_data;
  logic [RAM_WIDTH/8-1:0] mxu_byte_en;
  logic                   mxu_last;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport slave (
    input  cmd_vld, cmd_start_addr, cmd_stride, cmd_len, cmd_start_byte, cmd_end_byte,
    input  ram_rd_data_vld, ram_rd_data, mxu_rdy,
    output cmd_rdy, ram_rd_vld, ram_rd_addr, mxu_vld, mxu_data, mxu_byte_en, mxu_last,
    output busy, done, err
  );

  modport master (
    output cmd_vld, cmd_start_addr, cmd_stride, cmd_len, cmd_start_byte, cmd_end_byte,
    output ram_rd_data_vld, ram_rd_data, mxu_rdy,
    input  cmd_rdy, ram_rd_vld, ram_rd_addr, mxu_vld, mxu_data, mxu_byte_en, mxu_last,
    input  busy, done, err
  );
endinterface

// File: rtl/ram_fetch_buffer.sv
// Strided RAM row fetcher: credit-limited reads into a circular buffer, streamed
// in order to the MXU with per-byte enables on the first and last row.
module ram_fetch_buffer #(
  parameter int RAM_WIDTH = 128,
  parameter int RAM_AW    = 8,
  parameter int ENT_NUM   = 16,
  parameter int ENT_AW    = $clog2(ENT_NUM),
  parameter int BYTE_AW   = $clog2(RAM_WIDTH/8)
) (
  input logic               clk,
  input logic               rst,
  ram_fetch_buffer_if.slave bus
);
  localparam int LANES = RAM_WIDTH / 8;
  localparam int PW    = ENT_AW + 1;
  localparam int CW    = ENT_AW + 2;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                     state;
  logic [RAM_AW-1:0]          addr;
  logic signed [RAM_AW-1:0]   stride;
  logic [15:0]                len, issued, rcvd, popped;
  logic [BYTE_AW-1:0]         start_byte, end_byte;
  logic [PW-1:0]              wr_ptr, rd_ptr, count, outstanding, out_nxt;
  logic                       done_r, err_r;
  logic [RAM_WIDTH-1:0]       data_mem [ENT_NUM];
  logic [LANES-1:0]           en_mem   [ENT_NUM];
  logic [ENT_NUM-1:0]         last_mem;
  logic                       credit_ok, rd_req, push, stray, mxu_vld_w, pop, accept;

  function automatic logic [LANES-1:0] lane_mask(input logic [BYTE_AW-1:0] lo,
                                                 input logic [BYTE_AW-1:0] hi,
                                                 input logic first, input logic last);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++)
      m[i] = (!first || (BYTE_AW'(i) >= lo)) && (!last || (BYTE_AW'(i) <= hi));
    return m;
  endfunction

  assign count     = wr_ptr - rd_ptr;
  assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < CW'(ENT_NUM);
  assign rd_req    = (state == FETCH) && credit_ok;
  // A return with nothing in flight is dropped rather than corrupting the buffer.
  assign push      = bus.ram_rd_data_vld && (outstanding != '0);
  assign stray     = bus.ram_rd_data_vld && (outstanding == '0);
  assign mxu_vld_w = (count != '0);
  assign pop       = mxu_vld_w && bus.mxu_rdy;
  assign accept    = bus.cmd_vld && (state == IDLE);

  always_comb begin
    case ({rd_req, push})
      2'b10:   out_nxt = outstanding + PW'(1);
      2'b01:   out_nxt = outstanding - PW'(1);
      default: out_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      stride      <= '0;
      len         <= '0;
      issued      <= '0;
      rcvd        <= '0;
      popped      <= '0;
      start_byte  <= '0;
      end_byte    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          addr       <= bus.cmd_start_addr;
          stride     <= bus.cmd_stride;
          len        <= bus.cmd_len;
          start_byte <= bus.cmd_start_byte;
          end_byte   <= bus.cmd_end_byte;
          issued     <= '0;
          rcvd       <= '0;
          popped     <= '0;
          err_r      <= 1'b0;
          if (bus.cmd_len == 16'd0) done_r <= 1'b1;
          else                      state  <= FETCH;
        end
        FETCH: if (rd_req) begin
          addr   <= addr + $unsigned(stride);
          issued <= issued + 16'd1;
          if (issued == len - 16'd1) state <= DRAIN;
        end
        DRAIN: if (pop && (popped == len - 16'd1)) begin
          state  <= IDLE;
          done_r <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (stray) err_r <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        rcvd   <= rcvd + 16'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        popped <= popped + 16'd1;
      end
      outstanding <= out_nxt;
    end
  end

  // Buffer storage: data path, no reset; flags fixed at write time.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr[ENT_AW-1:0]] <= bus.ram_rd_data;
      en_mem[wr_ptr[ENT_AW-1:0]]   <= lane_mask(start_byte, end_byte,
                                                rcvd == 16'd0, rcvd == len - 16'd1);
      last_mem[wr_ptr[ENT_AW-1:0]] <= (rcvd == len - 16'd1);
    end
  end

  assign bus.cmd_rdy     = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.ram_rd_vld  = rd_req;
  assign bus.ram_rd_addr = addr;
  assign bus.mxu_vld     = mxu_vld_w;
  assign bus.mxu_data    = mxu_vld_w ? data_mem[rd_ptr[ENT_AW-1:0]] : '0;
  assign bus.mxu_byte_en = mxu_vld_w ? en_mem[rd_ptr[ENT_AW-1:0]] : '0;
  assign bus.mxu_last    = mxu_vld_w && last_mem[rd_ptr[ENT_AW-1:0]];
  assign bus.done        = done_r;
  assign bus.err         = err_r;
endmodule

// File: tb/tb_ram_fetch_buffer.sv
// Scoreboard bench for ram_fetch_buffer: a reference model queues expected read
// addresses and rows per command; independent processes model the RAM and the MXU.
module tb_ram_fetch_buffer;
  localparam int RAM_WIDTH = 128;
  localparam int RAM_AW    = 8;
  localparam int ENT_NUM   = 16;

  typedef struct { logic [127:0] data; logic [15:0] en; logic last; } row_t;
  typedef struct { logic [7:0] addr; int due; } req_t;

  logic clk = 1'b0;
  logic rst;

  ram_fetch_buffer_if #(.RAM_WIDTH(RAM_WIDTH), .RAM_AW(RAM_AW)) bus ();

  ram_fetch_buffer #(.RAM_WIDTH(RAM_WIDTH), .RAM_AW(RAM_AW), .ENT_NUM(ENT_NUM)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  row_t         exp_q[$];
  logic [7:0]   addr_q[$];
  req_t         req_q[$];
  logic [15:0]  en_log[$];
  logic [127:0] ram_mem [256];
  int checks = 0, errors = 0, cyc = 0, req_count = 0, last_pop_cyc = -1;
  int lat_min = 1, lat_max = 1, rdy_mode = 0;
  bit inject_stray = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_en(input int k, input int len, input int sb, input int eb);
    logic [15:0] m;
    for (int b = 0; b < 16; b++)
      m[b] = ((k != 0) || (b >= sb)) && ((k != len - 1) || (b <= eb));
    return m;
  endfunction

  // RAM model: checks each request address, returns rows in order after a random latency.
  initial begin
    req_t r;
    bus.ram_rd_data_vld = 1'b0;
    bus.ram_rd_data     = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.ram_rd_vld) begin
        req_count++;
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_extra: got request to %0h, expected no request", bus.ram_rd_addr);
        end else check("rd_addr", bus.ram_rd_addr, addr_q.pop_front());
        req_q.push_back('{addr: bus.ram_rd_addr, due: cyc + $urandom_range(lat_max, lat_min)});
      end
      @(posedge clk); #1;
      if (req_q.size() != 0 && req_q[0].due <= cyc) begin
        r = req_q.pop_front();
        bus.ram_rd_data_vld = 1'b1;
        bus.ram_rd_data     = ram_mem[r.addr];
      end else if (inject_stray) begin
        inject_stray        = 1'b0;
        bus.ram_rd_data_vld = 1'b1;
        bus.ram_rd_data     = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        bus.ram_rd_data_vld = 1'b0;
      end
    end
  end

  // MXU ready pattern: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    bus.mxu_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.mxu_rdy = 1'b1;
        1:       bus.mxu_rdy = 1'($urandom_range(1, 0));
        default: bus.mxu_rdy = 1'b0;
      endcase
    end
  end

  // Output monitor: compares each accepted row and holds a stalled row steady.
  initial begin
    row_t e, hr;
    bit held;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        check("hold_vld",  bus.mxu_vld,     1'b1);
        check("hold_data", bus.mxu_data,    hr.data);
        check("hold_en",   bus.mxu_byte_en, hr.en);
        check("hold_last", bus.mxu_last,    hr.last);
      end
      if (bus.mxu_vld && bus.mxu_rdy) begin
        held = 1'b0;
        en_log.push_back(bus.mxu_byte_en);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL row_extra: got row %0h, expected no row", bus.mxu_data);
        end else begin
          e = exp_q.pop_front();
          check("row_data", bus.mxu_data,    e.data);
          check("row_en",   bus.mxu_byte_en, e.en);
          check("row_last", bus.mxu_last,    e.last);
          if (e.last) last_pop_cyc = cyc;
        end
      end else if (bus.mxu_vld) begin
        held    = 1'b1;
        hr.data = bus.mxu_data;
        hr.en   = bus.mxu_byte_en;
        hr.last = bus.mxu_last;
      end else held = 1'b0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdy"}, bus.cmd_rdy,     1'b1);
    check({tag, "_busy"},    bus.busy,        1'b0);
    check({tag, "_rd_vld"},  bus.ram_rd_vld,  1'b0);
    check({tag, "_rd_addr"}, bus.ram_rd_addr, 8'h00);
    check({tag, "_mxu_vld"}, bus.mxu_vld,     1'b0);
    check({tag, "_data"},    bus.mxu_data,    128'h0);
    check({tag, "_en"},      bus.mxu_byte_en, 16'h0);
    check({tag, "_last"},    bus.mxu_last,    1'b0);
    check({tag, "_done"},    bus.done,        1'b0);
    check({tag, "_err"},     bus.err,         1'b0);
  endtask

  // Queues the model's view of a command, then presents it until accepted.
  task automatic send_cmd(input int sa, input int stride, input int len, input int sb,
                          input int eb, output bit acc_done, output bit post_vld,
                          output bit post_done, output bit post_err);
    row_t r;
    int a;
    bit ok;
    for (int k = 0; k < len; k++) begin
      a = (sa + k * stride) & 255;
      addr_q.push_back(8'(a));
      r.data = ram_mem[a];
      r.en   = model_en(k, len, sb, eb);
      r.last = (k == len - 1);
      exp_q.push_back(r);
    end
    @(posedge clk); #1;
    bus.cmd_vld        = 1'b1;
    bus.cmd_start_addr = 8'(sa);
    bus.cmd_stride     = 8'(stride);
    bus.cmd_len        = 16'(len);
    bus.cmd_start_byte = 4'(sb);
    bus.cmd_end_byte   = 4'(eb);
    ok = 1'b0;
    acc_done = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_rdy) begin
        ok = 1'b1;
        acc_done = bus.done;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL cmd_accept: got cmd_rdy=0 for 2000 cycles, expected accept");
    end
    @(posedge clk); #1;
    bus.cmd_vld = 1'b0;
    @(negedge clk);
    post_vld  = bus.ram_rd_vld;
    post_done = bus.done;
    post_err  = bus.err;
  endtask

  task automatic wait_done(input string name, input int len);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_done: got no done in 5000 cycles, expected done", name);
    end else begin
      if (len != 0) check({name, "_done_time"}, cyc, last_pop_cyc + 1);
      check({name, "_rows_left"}, exp_q.size(), 0);
      check({name, "_addrs_left"}, addr_q.size(), 0);
    end
    @(negedge clk);
  endtask

  initial begin
    bit ad, pv, pd, pe;
    int s;
    for (int i = 0; i < 256; i++) ram_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    rst = 1'b1;
    bus.cmd_vld = 1'b0;
    bus.cmd_start_addr = '0;
    bus.cmd_stride = '0;
    bus.cmd_len = '0;
    bus.cmd_start_byte = '0;
    bus.cmd_end_byte = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // basic increasing fetch
    en_log.delete();
    send_cmd(8'h10, 1, 4, 0, 15, ad, pv, pd, pe);
    check("basic_first_req", pv, 1'b1);
    wait_done("basic", 4);
    check("basic_rows", en_log.size(), 4);

    // negative stride wrapping through address 0
    lat_min = 1; lat_max = 3;
    send_cmd(8'h02, -1, 5, 0, 15, ad, pv, pd, pe);
    wait_done("wrap", 5);

    // partial byte lanes
    en_log.delete();
    send_cmd(8'h30, 1, 1, 3, 9, ad, pv, pd, pe);
    wait_done("single", 1);
    check("single_n", en_log.size(), 1);
    if (en_log.size() == 1) check("single_en", en_log[0], 16'h03F8);
    en_log.delete();
    send_cmd(8'h40, 2, 3, 4, 1, ad, pv, pd, pe);
    wait_done("partial", 3);
    check("partial_n", en_log.size(), 3);
    if (en_log.size() == 3) begin
      check("partial_en0", en_log[0], 16'hFFF0);
      check("partial_en1", en_log[1], 16'hFFFF);
      check("partial_en2", en_log[2], 16'h0003);
    end

    // zero-length command
    s = req_count;
    send_cmd(8'h55, 1, 0, 0, 15, ad, pv, pd, pe);
    check("len0_done", pd, 1'b1);
    check("len0_rd_vld", pv, 1'b0);
    check("len0_reqs", req_count - s, 0);

    // backpressure fills the buffer and stops requesting
    lat_min = 1; lat_max = 2;
    rdy_mode = 2;
    s = req_count;
    send_cmd(8'h80, 1, 40, 2, 13, ad, pv, pd, pe);
    repeat (50) @(negedge clk);
    check("bp_reqs", req_count - s, ENT_NUM);
    check("bp_rd_vld", bus.ram_rd_vld, 1'b0);
    check("bp_mxu_vld", bus.mxu_vld, 1'b1);
    rdy_mode = 0;
    wait_done("bp", 40);

    // stray return while idle
    inject_stray = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_err", bus.err, 1'b1);
    check("stray_mxu_vld", bus.mxu_vld, 1'b0);
    send_cmd(8'h05, 3, 6, 1, 14, ad, pv, pd, pe);
    check("stray_err_clear", pe, 1'b0);
    wait_done("after_stray", 6);

    // back-to-back commands: second accepted in the done cycle of the first
    rdy_mode = 1;
    send_cmd(8'hF0, 5, 7, 6, 8, ad, pv, pd, pe);
    send_cmd(8'h11, -3, 9, 0, 3, ad, pv, pd, pe);
    check("b2b_done_at_accept", ad, 1'b1);
    check("b2b_first_req", pv, 1'b1);
    wait_done("b2b", 9);

    // randomized commands
    for (int n = 0; n < 12; n++) begin
      s = $urandom_range(255, 0);
      if (s > 127) s -= 256;
      lat_max = $urandom_range(4, 1);
      rdy_mode = $urandom_range(1, 0);
      send_cmd($urandom_range(255, 0), s, $urandom_range(20, 1), $urandom_range(15, 0),
               $urandom_range(15, 0), ad, pv, pd, pe);
      wait_done("rand", 1);
    end

    // asynchronous reset in the middle of a fetch
    rdy_mode = 0; lat_max = 2;
    send_cmd(8'h20, 1, 40, 0, 15, ad, pv, pd, pe);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    req_q.delete();
    exp_q.delete();
    addr_q.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("postrst");
    rdy_mode = 1;
    send_cmd(8'hC3, 7, 10, 5, 10, ad, pv, pd, pe);
    wait_done("recover", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
